// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: turns one core-side request into a single INCR burst on the
// 64-bit memory bus and returns a completion carrying a sticky error flag.
module axi_burst_master #(
   parameter logic [4:0] ID   = 5'd0,
   parameter logic [4:0] USER = 5'd0
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_len,

   input  logic        wdata_valid,
   output logic        wdata_ready,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,

   output logic        rdata_valid,
   input  logic        rdata_ready,
   output logic [63:0] rdata,
   output logic        rlast,

   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_err,

   input  logic        axi_aw_ready,
   output logic        axi_aw_valid,
   output logic [31:0] axi_aw_bits_addr,
   output logic [7:0]  axi_aw_bits_len,
   output logic [2:0]  axi_aw_bits_size,
   output logic [1:0]  axi_aw_bits_burst,
   output logic        axi_aw_bits_lock,
   output logic [3:0]  axi_aw_bits_cache,
   output logic [2:0]  axi_aw_bits_prot,
   output logic [3:0]  axi_aw_bits_qos,
   output logic [3:0]  axi_aw_bits_region,
   output logic [4:0]  axi_aw_bits_id,
   output logic [4:0]  axi_aw_bits_user,

   input  logic        axi_w_ready,
   output logic        axi_w_valid,
   output logic [63:0] axi_w_bits_data,
   output logic [7:0]  axi_w_bits_strb,
   output logic        axi_w_bits_last,
   output logic [4:0]  axi_w_bits_id,
   output logic [4:0]  axi_w_bits_user,

   output logic        axi_b_ready,
   input  logic        axi_b_valid,
   input  logic [1:0]  axi_b_bits_resp,
   input  logic [4:0]  axi_b_bits_id,

   input  logic        axi_ar_ready,
   output logic        axi_ar_valid,
   output logic [31:0] axi_ar_bits_addr,
   output logic [7:0]  axi_ar_bits_len,
   output logic [2:0]  axi_ar_bits_size,
   output logic [1:0]  axi_ar_bits_burst,
   output logic        axi_ar_bits_lock,
   output logic [3:0]  axi_ar_bits_cache,
   output logic [2:0]  axi_ar_bits_prot,
   output logic [3:0]  axi_ar_bits_qos,
   output logic [3:0]  axi_ar_bits_region,
   output logic [4:0]  axi_ar_bits_id,
   output logic [4:0]  axi_ar_bits_user,

   output logic        axi_r_ready,
   input  logic        axi_r_valid,
   input  logic [63:0] axi_r_bits_data,
   input  logic [1:0]  axi_r_bits_resp,
   input  logic        axi_r_bits_last,
   input  logic [4:0]  axi_r_bits_id
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;
   localparam logic [2:0] S_RESP = 3'd6;

   logic [2:0]  r_state;
   logic [31:0] r_addr;
   logic [7:0]  r_len;
   logic [7:0]  r_beat_cnt;
   logic        r_err;

   logic        w_last_beat;
   logic        w_r_fire;
   logic        w_w_fire;
   logic        w_r_bad;
   logic        w_b_bad;
   logic [31:0] w_req_addr_aligned;

   assign w_req_addr_aligned = req_addr & ~32'h7;
   assign w_last_beat        = (r_beat_cnt == 8'd0);
   assign w_r_fire           = (r_state == S_R) & axi_r_valid & rdata_ready;
   assign w_w_fire           = (r_state == S_W) & wdata_valid & axi_w_ready;
   // A wrong RLAST only flags an error; the beat counter alone decides when the burst ends.
   assign w_r_bad            = (axi_r_bits_resp != 2'd0) | (axi_r_bits_last != w_last_beat) |
                               (axi_r_bits_id != ID);
   assign w_b_bad            = (axi_b_bits_resp != 2'd0) | (axi_b_bits_id != ID);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_addr     <= 32'd0;
         r_len      <= 8'd0;
         r_beat_cnt <= 8'd0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr     <= w_req_addr_aligned;
                  r_len      <= req_len;
                  r_beat_cnt <= req_len;
                  r_err      <= 1'b0;
                  r_state    <= req_write ? S_AW : S_AR;
               end
            end
            S_AR: begin
               if (axi_ar_ready) r_state <= S_R;
            end
            S_R: begin
               if (w_r_fire) begin
                  if (w_r_bad) r_err <= 1'b1;
                  if (w_last_beat) r_state <= S_RESP;
                  else r_beat_cnt <= r_beat_cnt - 8'd1;
               end
            end
            S_AW: begin
               if (axi_aw_ready) r_state <= S_W;
            end
            S_W: begin
               if (w_w_fire) begin
                  if (w_last_beat) r_state <= S_B;
                  else r_beat_cnt <= r_beat_cnt - 8'd1;
               end
            end
            S_B: begin
               if (axi_b_valid) begin
                  if (w_b_bad) r_err <= 1'b1;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign resp_valid  = (r_state == S_RESP);
   assign resp_err    = r_err;

   assign axi_ar_valid       = (r_state == S_AR);
   assign axi_ar_bits_addr   = r_addr;
   assign axi_ar_bits_len    = r_len;
   assign axi_ar_bits_size   = 3'h3;
   assign axi_ar_bits_burst  = 2'h1;
   assign axi_ar_bits_lock   = 1'b0;
   assign axi_ar_bits_cache  = 4'h0;
   assign axi_ar_bits_prot   = 3'h0;
   assign axi_ar_bits_qos    = 4'h0;
   assign axi_ar_bits_region = 4'h0;
   assign axi_ar_bits_id     = ID;
   assign axi_ar_bits_user   = USER;

   assign axi_aw_valid       = (r_state == S_AW);
   assign axi_aw_bits_addr   = r_addr;
   assign axi_aw_bits_len    = r_len;
   assign axi_aw_bits_size   = 3'h3;
   assign axi_aw_bits_burst  = 2'h1;
   assign axi_aw_bits_lock   = 1'b0;
   assign axi_aw_bits_cache  = 4'h0;
   assign axi_aw_bits_prot   = 3'h0;
   assign axi_aw_bits_qos    = 4'h0;
   assign axi_aw_bits_region = 4'h0;
   assign axi_aw_bits_id     = ID;
   assign axi_aw_bits_user   = USER;

   // Data beats pass straight through; the state gates keep W silent until AW has gone.
   assign axi_r_ready     = (r_state == S_R) & rdata_ready;
   assign rdata_valid     = (r_state == S_R) & axi_r_valid;
   assign rdata           = axi_r_bits_data;
   assign rlast           = (r_state == S_R) & w_last_beat;

   assign axi_w_valid     = (r_state == S_W) & wdata_valid;
   assign wdata_ready     = (r_state == S_W) & axi_w_ready;
   assign axi_w_bits_data = wdata;
   assign axi_w_bits_strb = wstrb;
   assign axi_w_bits_last = (r_state == S_W) & w_last_beat;
   assign axi_w_bits_id   = ID;
   assign axi_w_bits_user = USER;

   assign axi_b_ready     = (r_state == S_B);

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI memory responder, a table of directed
// transactions, and hand-written sequences for backpressure and mid-burst reset.
module tb_axi_burst_master;

   localparam logic [4:0]  TB_ID    = 5'd3;
   localparam logic [4:0]  TB_USER  = 5'd5;
   localparam logic [30:0] EXP_MISC = {3'h3, 2'h1, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, TB_ID, TB_USER};

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic        wdata_valid, wdata_ready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        rdata_valid, rdata_ready, rlast;
   logic [63:0] rdata;
   logic        resp_valid, resp_ready, resp_err;

   logic        axi_aw_ready, axi_aw_valid, axi_aw_bits_lock;
   logic [31:0] axi_aw_bits_addr;
   logic [7:0]  axi_aw_bits_len;
   logic [2:0]  axi_aw_bits_size, axi_aw_bits_prot;
   logic [1:0]  axi_aw_bits_burst;
   logic [3:0]  axi_aw_bits_cache, axi_aw_bits_qos, axi_aw_bits_region;
   logic [4:0]  axi_aw_bits_id, axi_aw_bits_user;
   logic        axi_w_ready, axi_w_valid, axi_w_bits_last;
   logic [63:0] axi_w_bits_data;
   logic [7:0]  axi_w_bits_strb;
   logic [4:0]  axi_w_bits_id, axi_w_bits_user;
   logic        axi_b_ready, axi_b_valid;
   logic [1:0]  axi_b_bits_resp;
   logic [4:0]  axi_b_bits_id;
   logic        axi_ar_ready, axi_ar_valid, axi_ar_bits_lock;
   logic [31:0] axi_ar_bits_addr;
   logic [7:0]  axi_ar_bits_len;
   logic [2:0]  axi_ar_bits_size, axi_ar_bits_prot;
   logic [1:0]  axi_ar_bits_burst;
   logic [3:0]  axi_ar_bits_cache, axi_ar_bits_qos, axi_ar_bits_region;
   logic [4:0]  axi_ar_bits_id, axi_ar_bits_user;
   logic        axi_r_ready, axi_r_valid, axi_r_bits_last;
   logic [63:0] axi_r_bits_data;
   logic [1:0]  axi_r_bits_resp;
   logic [4:0]  axi_r_bits_id;

   axi_burst_master #(.ID(TB_ID), .USER(TB_USER)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rlast(rlast),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
      .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid),
      .axi_aw_bits_addr(axi_aw_bits_addr), .axi_aw_bits_len(axi_aw_bits_len),
      .axi_aw_bits_size(axi_aw_bits_size), .axi_aw_bits_burst(axi_aw_bits_burst),
      .axi_aw_bits_lock(axi_aw_bits_lock), .axi_aw_bits_cache(axi_aw_bits_cache),
      .axi_aw_bits_prot(axi_aw_bits_prot), .axi_aw_bits_qos(axi_aw_bits_qos),
      .axi_aw_bits_region(axi_aw_bits_region), .axi_aw_bits_id(axi_aw_bits_id),
      .axi_aw_bits_user(axi_aw_bits_user),
      .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid),
      .axi_w_bits_data(axi_w_bits_data), .axi_w_bits_strb(axi_w_bits_strb),
      .axi_w_bits_last(axi_w_bits_last), .axi_w_bits_id(axi_w_bits_id),
      .axi_w_bits_user(axi_w_bits_user),
      .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid),
      .axi_b_bits_resp(axi_b_bits_resp), .axi_b_bits_id(axi_b_bits_id),
      .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid),
      .axi_ar_bits_addr(axi_ar_bits_addr), .axi_ar_bits_len(axi_ar_bits_len),
      .axi_ar_bits_size(axi_ar_bits_size), .axi_ar_bits_burst(axi_ar_bits_burst),
      .axi_ar_bits_lock(axi_ar_bits_lock), .axi_ar_bits_cache(axi_ar_bits_cache),
      .axi_ar_bits_prot(axi_ar_bits_prot), .axi_ar_bits_qos(axi_ar_bits_qos),
      .axi_ar_bits_region(axi_ar_bits_region), .axi_ar_bits_id(axi_ar_bits_id),
      .axi_ar_bits_user(axi_ar_bits_user),
      .axi_r_ready(axi_r_ready), .axi_r_valid(axi_r_valid),
      .axi_r_bits_data(axi_r_bits_data), .axi_r_bits_resp(axi_r_bits_resp),
      .axi_r_bits_last(axi_r_bits_last), .axi_r_bits_id(axi_r_bits_id)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // ---------------- responder ----------------
   logic        bp = 1'b0;
   logic [1:0]  inj_rresp = 2'd0, inj_bresp = 2'd0;
   logic        inj_rflip = 1'b0, inj_rid = 1'b0, inj_bid = 1'b0;

   logic [63:0] mem [0:4095];
   logic        rd_act, wr_act, b_valid_q, w_gate, ar_rdy_q, aw_rdy_q;
   logic [11:0] rd_word, wr_word;
   logic [7:0]  rd_len, rd_cnt, wr_len, wr_cnt;
   logic [31:0] cap_ar_addr, cap_aw_addr;
   logic [7:0]  cap_ar_len, cap_aw_len;
   logic [30:0] cap_ar_misc, cap_aw_misc;

   assign axi_ar_ready    = ar_rdy_q;
   assign axi_aw_ready    = aw_rdy_q;
   assign axi_r_valid     = rd_act;
   assign axi_r_bits_data = mem[rd_word + 12'(rd_cnt)];
   assign axi_r_bits_resp = inj_rresp;
   assign axi_r_bits_last = (rd_cnt == rd_len) ^ inj_rflip;
   assign axi_r_bits_id   = inj_rid ? (TB_ID ^ 5'd1) : TB_ID;
   assign axi_w_ready     = wr_act & w_gate;
   assign axi_b_valid     = b_valid_q;
   assign axi_b_bits_resp = inj_bresp;
   assign axi_b_bits_id   = inj_bid ? (TB_ID ^ 5'd1) : TB_ID;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_act <= 1'b0; wr_act <= 1'b0; b_valid_q <= 1'b0;
         w_gate <= 1'b0; ar_rdy_q <= 1'b0; aw_rdy_q <= 1'b0;
         rd_word <= '0; wr_word <= '0; rd_len <= '0; rd_cnt <= '0; wr_len <= '0; wr_cnt <= '0;
         cap_ar_addr <= '0; cap_aw_addr <= '0; cap_ar_len <= '0; cap_aw_len <= '0;
         cap_ar_misc <= '0; cap_aw_misc <= '0;
         for (int k = 0; k < 4096; k++)
            mem[k] <= (k >= 512 && k < 516) ? 64'(k - 512) : (64'h1111_0000_0000_0000 + 64'(k));
      end else begin
         ar_rdy_q <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
         aw_rdy_q <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
         w_gate   <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (axi_ar_valid && ar_rdy_q) begin
            rd_act <= 1'b1; rd_word <= axi_ar_bits_addr[14:3]; rd_len <= axi_ar_bits_len; rd_cnt <= 8'd0;
            cap_ar_addr <= axi_ar_bits_addr; cap_ar_len <= axi_ar_bits_len;
            cap_ar_misc <= {axi_ar_bits_size, axi_ar_bits_burst, axi_ar_bits_lock, axi_ar_bits_cache,
                            axi_ar_bits_prot, axi_ar_bits_qos, axi_ar_bits_region, axi_ar_bits_id,
                            axi_ar_bits_user};
         end
         if (rd_act && axi_r_ready) begin
            rd_cnt <= rd_cnt + 8'd1;
            if (rd_cnt == rd_len) rd_act <= 1'b0;
         end
         if (axi_aw_valid && aw_rdy_q) begin
            wr_act <= 1'b1; wr_word <= axi_aw_bits_addr[14:3]; wr_len <= axi_aw_bits_len; wr_cnt <= 8'd0;
            cap_aw_addr <= axi_aw_bits_addr; cap_aw_len <= axi_aw_bits_len;
            cap_aw_misc <= {axi_aw_bits_size, axi_aw_bits_burst, axi_aw_bits_lock, axi_aw_bits_cache,
                            axi_aw_bits_prot, axi_aw_bits_qos, axi_aw_bits_region, axi_aw_bits_id,
                            axi_aw_bits_user};
         end
         if (wr_act && w_gate && axi_w_valid) begin
            for (int j = 0; j < 8; j++)
               if (axi_w_bits_strb[j]) mem[wr_word + 12'(wr_cnt)][j*8 +: 8] <= axi_w_bits_data[j*8 +: 8];
            wr_cnt <= wr_cnt + 8'd1;
            if (wr_cnt == wr_len) begin
               wr_act <= 1'b0;
               b_valid_q <= 1'b1;
            end
         end
         if (b_valid_q && axi_b_ready) b_valid_q <= 1'b0;
      end
   end

   // ---------------- protocol monitor ----------------
   logic        p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0;
   logic [31:0] p_ara = '0, p_awa = '0;
   logic [7:0]  p_arl = '0, p_awl = '0;

   always @(negedge clock) begin
      if (reset) begin
         if (p_arv && !p_arr)
            chk("ar_hold", {23'd0, axi_ar_valid, axi_ar_bits_addr, axi_ar_bits_len}, {23'd0, 1'b1, p_ara, p_arl});
         if (p_awv && !p_awr)
            chk("aw_hold", {23'd0, axi_aw_valid, axi_aw_bits_addr, axi_aw_bits_len}, {23'd0, 1'b1, p_awa, p_awl});
         if (axi_w_valid)
            chk("w_after_aw", 64'(wr_act), 64'd1);
      end
      p_arv <= reset & axi_ar_valid; p_arr <= axi_ar_ready; p_ara <= axi_ar_bits_addr; p_arl <= axi_ar_bits_len;
      p_awv <= reset & axi_aw_valid; p_awr <= axi_aw_ready; p_awa <= axi_aw_bits_addr; p_awl <= axi_aw_bits_len;
   end

   // ---------------- transaction table ----------------
   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic        bp;
      logic [1:0]  rresp;
      logic        rflip;
      logic        ridbad;
      logic [1:0]  bresp;
      logic        bidbad;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [7:0]  s0;
      logic [7:0]  s1;
      logic        exp_err;
      logic [31:0] exp_ax;
   } vec_t;

   // Beats 0/1 take d0/d1 from the record; later beats follow d0 + beat index.
   function automatic logic [63:0] beat_val(input logic [63:0] d0, input logic [63:0] d1, input int b);
      if (b == 0) return d0;
      if (b == 1) return d1;
      return d0 + 64'(b);
   endfunction

   task automatic do_req(input logic wr, input logic [31:0] a, input logic [7:0] l, input int tag);
      @(negedge clock);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
      #1;
      chk($sformatf("txn%0d_req_ready", tag), 64'(req_ready), 64'd1);
      chk($sformatf("txn%0d_no_comb_ax", tag), {62'd0, axi_ar_valid, axi_aw_valid}, 64'd0);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      chk($sformatf("txn%0d_ax_valid_next", tag), 64'(wr ? axi_aw_valid : axi_ar_valid), 64'd1);
      chk($sformatf("txn%0d_busy", tag), 64'(req_ready), 64'd0);
   endtask

   task automatic run_txn(input vec_t v, input int tag);
      int beats, it, last_it, resp_it;
      logic got;
      bp = v.bp; inj_rresp = v.rresp; inj_rflip = v.rflip; inj_rid = v.ridbad;
      inj_bresp = v.bresp; inj_bid = v.bidbad;
      do_req(v.wr, v.addr, v.len, tag);
      beats = 0; it = 0; last_it = -1; resp_it = -1; got = 1'b0;
      while (!got && it < 3000) begin
         @(negedge clock);
         if (v.wr) begin
            wdata = beat_val(v.d0, v.d1, beats);
            wstrb = (beats == 0) ? v.s0 : (beats == 1) ? v.s1 : 8'hFF;
            wdata_valid = (beats <= int'(v.len)) ? (v.bp ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
         end else begin
            rdata_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         #1;
         if (resp_valid) begin
            got = 1'b1; resp_it = it;
         end else if (v.wr && wdata_valid && wdata_ready) begin
            chk($sformatf("txn%0d_wlast_id%0d", tag, beats),
                {53'd0, axi_w_bits_last, axi_w_bits_id, axi_w_bits_user},
                {53'd0, (beats == int'(v.len)), TB_ID, TB_USER});
            beats++; last_it = it;
         end else if (!v.wr && rdata_valid && rdata_ready) begin
            chk($sformatf("txn%0d_rdata%0d", tag, beats), rdata, beat_val(v.d0, v.d1, beats));
            chk($sformatf("txn%0d_rlast%0d", tag, beats), 64'(rlast), 64'(beats == int'(v.len)));
            beats++; last_it = it;
         end
         it++;
      end
      wdata_valid = 1'b0; rdata_ready = 1'b0;
      if (!got) begin
         n_cmp++; n_fail++;
         $display("FAIL txn%0d_resp_timeout: got resp_valid=0 after %0d cycles, required resp_valid=1", tag, it);
      end else begin
         chk($sformatf("txn%0d_resp_err", tag), 64'(resp_err), 64'(v.exp_err));
         chk($sformatf("txn%0d_resp_latency", tag), 64'(resp_it - last_it), v.wr ? 64'd2 : 64'd1);
         resp_ready = 1'b1;
         @(posedge clock);
         #1;
         resp_ready = 1'b0;
         chk($sformatf("txn%0d_idle_after_resp", tag), 64'(req_ready), 64'd1);
      end
      chk($sformatf("txn%0d_beats", tag), 64'(beats), 64'(int'(v.len) + 1));
      if (v.wr)
         chk($sformatf("txn%0d_aw_fields", tag), {cap_aw_misc, cap_aw_len, 25'd0}, {EXP_MISC, v.len, 25'd0});
      else
         chk($sformatf("txn%0d_ar_fields", tag), {cap_ar_misc, cap_ar_len, 25'd0}, {EXP_MISC, v.len, 25'd0});
      chk($sformatf("txn%0d_ax_addr", tag), 64'(v.wr ? cap_aw_addr : cap_ar_addr), 64'(v.exp_ax));
      $display("txn %0d: %s addr=%h len=%0d beats=%0d resp_err=%0d", tag, v.wr ? "write" : "read",
               v.addr, v.len, beats, resp_err);
      bp = 1'b0; inj_rresp = 2'd0; inj_rflip = 1'b0; inj_rid = 1'b0; inj_bresp = 2'd0; inj_bid = 1'b0;
   endtask

   vec_t vecs [14];

   initial begin
      int rb, rit;
      req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
      wdata_valid = 0; wdata = '0; wstrb = '0; rdata_ready = 0; resp_ready = 0;

      //             wr    addr          len   bp    rresp rflip rid   bresp bid   d0                      d1                      s0     s1     err   exp_ax
      vecs[0]  = '{1'b0, 32'h0000_1000, 8'd3,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0,                  64'h1,                  8'h00, 8'h00, 1'b0, 32'h0000_1000};
      vecs[1]  = '{1'b1, 32'h0000_2008, 8'd1,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 8'h0F, 1'b0, 32'h0000_2008};
      vecs[2]  = '{1'b0, 32'h0000_2008, 8'd1,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1111_0000_BBBB_BBBB, 8'h00, 8'h00, 1'b0, 32'h0000_2008};
      vecs[3]  = '{1'b1, 32'h0000_3000, 8'd15, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h5000_0000_0000_0000, 64'h5000_0000_0000_0001, 8'hFF, 8'hFF, 1'b0, 32'h0000_3000};
      vecs[4]  = '{1'b0, 32'h0000_3000, 8'd15, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h5000_0000_0000_0000, 64'h5000_0000_0000_0001, 8'h00, 8'h00, 1'b0, 32'h0000_3000};
      vecs[5]  = '{1'b1, 32'h0000_3100, 8'd0,  1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 64'h7777_7777_7777_7777, 64'h0,                  8'hFF, 8'h00, 1'b1, 32'h0000_3100};
      vecs[6]  = '{1'b0, 32'h0000_1000, 8'd0,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0,                  64'h0,                  8'h00, 8'h00, 1'b0, 32'h0000_1000};
      vecs[7]  = '{1'b0, 32'h0000_1018, 8'd1,  1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 64'h3,                  64'h1111_0000_0000_0204, 8'h00, 8'h00, 1'b1, 32'h0000_1018};
      vecs[8]  = '{1'b0, 32'h0000_1008, 8'd1,  1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 64'h1,                  64'h2,                  8'h00, 8'h00, 1'b1, 32'h0000_1008};
      vecs[9]  = '{1'b0, 32'h0000_1000, 8'd0,  1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 64'h0,                  64'h0,                  8'h00, 8'h00, 1'b1, 32'h0000_1000};
      vecs[10] = '{1'b1, 32'h0000_3200, 8'd0,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0,                  8'hFF, 8'h00, 1'b1, 32'h0000_3200};
      vecs[11] = '{1'b0, 32'h0000_1007, 8'd0,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0,                  64'h0,                  8'h00, 8'h00, 1'b0, 32'h0000_1000};
      vecs[12] = '{1'b1, 32'h0000_2800, 8'd255,1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h9000_0000_0000_0000, 64'h9000_0000_0000_0001, 8'hFF, 8'hFF, 1'b0, 32'h0000_2800};
      vecs[13] = '{1'b0, 32'h0000_2800, 8'd255,1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h9000_0000_0000_0000, 64'h9000_0000_0000_0001, 8'h00, 8'h00, 1'b0, 32'h0000_2800};

      repeat (3) @(negedge clock);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_valids", {59'd0, axi_ar_valid, axi_aw_valid, axi_w_valid, resp_valid, rdata_valid}, 64'd0);
      chk("rst_readies", {61'd0, axi_r_ready, axi_b_ready, wdata_ready}, 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_ar_addr_len", {24'd0, axi_ar_bits_addr, axi_ar_bits_len}, 64'd0);
      chk("rst_aw_addr_len", {24'd0, axi_aw_bits_addr, axi_aw_bits_len}, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

      // Reset lands while the third beat of an 8-beat read is on the bus.
      do_req(1'b0, 32'h0000_1000, 8'd7, 50);
      rb = 0; rit = 0;
      while (rb < 2 && rit < 100) begin
         @(negedge clock);
         rdata_ready = 1'b1;
         #1;
         if (rdata_valid) begin
            chk($sformatf("rst_burst_rdata%0d", rb), rdata, 64'(rb));
            rb++;
         end
         rit++;
      end
      chk("rst_burst_two_beats", 64'(rb), 64'd2);
      #5;
      reset = 1'b0;
      #1;
      chk("async_drop_valids", {60'd0, axi_ar_valid, rdata_valid, resp_valid, axi_r_ready}, 64'd0);
      chk("async_req_ready", 64'(req_ready), 64'd1);
      $display("txn 50: read addr=00001000 len=7 reset after %0d beats", rb);
      rdata_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (2) begin
         @(negedge clock);
         #1;
         chk("no_resume", {60'd0, axi_ar_valid, rdata_valid, resp_valid, axi_r_ready}, 64'd0);
      end
      run_txn(vecs[11], 51);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule
